sprite_compositor: RTL and testbench
====================================

SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

Interface
REQ-001 Parameter NSPR, default 4, number of sprite inputs (1..8).
REQ-002 Parameter CIDXW, default 3, colour-index width; index 0 is transparent.
REQ-003 Parameter COLRW, default 12, RGB output width (4:4:4).
REQ-004 Parameter BG_COLOR, default 12'h000, colour shown when no sprite is opaque.
REQ-005 clk  in  1  pixel clock (25 MHz clk25 domain).
REQ-006 rst  in  1  synchronous, active-low reset; sampled on rising clk only.
REQ-007 frame  in  1  one-cycle pulse at start of frame.
REQ-008 bright  in  1  display-active flag, aligned with spr_* inputs.
REQ-009 spr_drawing  in  NSPR  per-sprite "inside bitmap" flag; bit i belongs to sprite i.
REQ-010 spr_pix  in  NSPR*CIDXW  per-sprite colour index; slice i is [i*CIDXW +: CIDXW].
REQ-011 pal_we  in  1  palette write strobe.
REQ-012 pal_addr  in  CIDXW  palette write address.
REQ-013 pal_data  in  COLRW  palette write data.
REQ-014 rgb  out  COLRW  composited pixel colour.
REQ-015 rgb_valid  out  1  bright delayed to align with rgb.
REQ-016 collision  out  NSPR  per-sprite collision flags for the previous completed frame.
REQ-017 collision_any  out  1  OR of collision.

Function
REQ-018 Sprite i SHALL be opaque in a cycle iff spr_drawing[i]=1 and its spr_pix slice is not 0.
REQ-019 Stage 1 SHALL register the winning index: the lowest-numbered opaque sprite wins; if none is opaque, register "none".
REQ-020 Stage 2 SHALL look up the winner's index in a 2^CIDXW x COLRW palette and register it to rgb; "none" SHALL give BG_COLOR.
REQ-021 Latency from spr_*/bright to rgb/rgb_valid SHALL be exactly 2 clk cycles, with no bubbles; one pixel per cycle.
REQ-022 When the 2-cycle-delayed bright is 0, rgb SHALL be 0 and rgb_valid SHALL be 0.
REQ-023 A palette write SHALL take effect on the clk edge where pal_we=1.
REQ-024 A stage-2 lookup in that same cycle SHALL return the old entry (read-before-write).
REQ-025 Palette writes SHALL be accepted regardless of bright or frame.
REQ-026 Each cycle with bright=1 and at least two opaque sprites SHALL set the accumulator bit of every opaque sprite; bits are sticky.
REQ-027 Collision detection SHALL use raw stage-0 inputs, so priority does not mask it.
REQ-028 On frame=1, collision SHALL load the accumulator value including the current cycle's hits, and the accumulator SHALL then clear.
REQ-029 A hit in the frame=1 cycle SHALL be counted in the ending frame only.
REQ-030 With NSPR=1, collision SHALL stay 0.

Reset
REQ-031 On rst=0 at a clk edge, the following SHALL all become 0: both pipeline stages, rgb, rgb_valid, collision, collision_any and the accumulator.
REQ-032 Every palette entry SHALL reset to 0.
REQ-033 Reset SHALL override pal_we and frame in the same cycle.
REQ-034 After rst returns to 1, rgb_valid SHALL stay 0 for 2 cycles; outputs before the first frame pulse SHALL be collision=0.

Verification
REQ-035 Palette: write idx1=12'hF00, idx2=12'h0F0; drive sprite0 pix=1 and sprite1 pix=2, both drawing, bright=1 -> rgb=12'hF00 exactly 2 cycles later.
REQ-036 Transparency: sprite0 pix=0, sprite1 pix=2 -> rgb=12'h0F0, and no collision is accumulated.
REQ-037 Blanking: bright=0 with opaque sprites -> rgb=0 and rgb_valid=0 after 2 cycles; none opaque with bright=1 -> rgb=BG_COLOR.
REQ-038 Collision: sprite0 and sprite2 opaque together for 1 cycle in frame N; frame pulse -> collision=4'b0101 and collision_any=1; next frame pulse with no overlap -> collision=0.
REQ-039 Boundary: write idx1=12'h00F while a stage-2 read of idx1 occurs in the same cycle -> that pixel shows the old value and the next pixel shows 12'h00F; a collision coincident with frame appears at that frame pulse.
REQ-040 Reset mid-line: assert rst=0 for 1 cycle during an opaque span -> all outputs 0 next cycle, palette cleared, rgb_valid resumes 2 cycles after release.

Source files
------------

// File: rtl/sprite_compositor.sv
// sprite_compositor: priority-composites NSPR sprites through a palette into a 2-stage RGB pipeline,
// and reports per-sprite overlap flags for the previous completed frame.
module sprite_compositor #(
  parameter int NSPR = 4,
  parameter int CIDXW = 3,
  parameter int COLRW = 12,
  parameter logic [COLRW-1:0] BG_COLOR = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame,
  input  logic                   bright,
  input  logic [NSPR-1:0]        spr_drawing,
  input  logic [NSPR*CIDXW-1:0]  spr_pix,
  input  logic                   pal_we,
  input  logic [CIDXW-1:0]       pal_addr,
  input  logic [COLRW-1:0]       pal_data,
  output logic [COLRW-1:0]       rgb,
  output logic                   rgb_valid,
  output logic [NSPR-1:0]        collision,
  output logic                   collision_any
);
  localparam int NPAL = 1 << CIDXW;
  logic [NSPR-1:0]  opaque;
  logic [CIDXW-1:0] win_idx;
  logic             multi;
  logic             s1_bright_q;
  logic             s1_hit_q;
  logic [CIDXW-1:0] s1_idx_q;
  logic [COLRW-1:0] rgb_q;
  logic [COLRW-1:0] rgb_d;
  logic             rgb_valid_q;
  logic [NSPR-1:0]  acc_q;
  logic [NSPR-1:0]  acc_d;
  logic [NSPR-1:0]  col_q;
  logic [COLRW-1:0] pal_q [NPAL];
  for (genvar g = 0; g < NSPR; g++) begin : g_opq
    assign opaque[g] = spr_drawing[g] && (spr_pix[g*CIDXW +: CIDXW] != '0);
  end
  // Scan from the top so the lowest-numbered opaque sprite is the last to overwrite.
  always_comb begin
    win_idx = '0;
    for (int i = NSPR - 1; i >= 0; i--)
      if (opaque[i]) win_idx = spr_pix[i*CIDXW +: CIDXW];
  end
  // Clearing the lowest set bit leaves something only if two or more sprites are opaque.
  assign multi = |(opaque & (opaque - NSPR'(1)));
  assign acc_d = acc_q | ((bright && multi) ? opaque : '0);
  assign rgb_d = !s1_bright_q ? '0 : s1_hit_q ? pal_q[s1_idx_q] : BG_COLOR;
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_bright_q <= 1'b0;
      s1_hit_q    <= 1'b0;
      s1_idx_q    <= '0;
      rgb_q       <= '0;
      rgb_valid_q <= 1'b0;
      acc_q       <= '0;
      col_q       <= '0;
      for (int i = 0; i < NPAL; i++) pal_q[i] <= '0;
    end else begin
      s1_bright_q <= bright;
      s1_hit_q    <= |opaque;
      s1_idx_q    <= win_idx;
      rgb_q       <= rgb_d;
      rgb_valid_q <= s1_bright_q;
      acc_q       <= frame ? '0 : acc_d;
      if (frame) col_q <= acc_d;
      if (pal_we) pal_q[pal_addr] <= pal_data;
    end
  end
  assign rgb           = rgb_q;
  assign rgb_valid     = rgb_valid_q;
  assign collision     = col_q;
  assign collision_any = |col_q;
endmodule

// File: tb/tb_sprite_compositor.sv
// tb_sprite_compositor: directed scenarios plus randomized traffic checked against a cycle-level reference model.
module tb_sprite_compositor;
  localparam int NS = 4;
  localparam int CW = 3;
  localparam int RW = 12;
  localparam logic [RW-1:0] BG = 12'h5A3;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic frame, bright, pal_we;
  logic [NS-1:0] spr_drawing;
  logic [NS*CW-1:0] spr_pix;
  logic [CW-1:0] pal_addr;
  logic [RW-1:0] pal_data;
  logic [RW-1:0] rgb;
  logic rgb_valid, collision_any;
  logic [NS-1:0] collision;
  int n_cmp = 0;
  int n_bad = 0;
  logic [RW-1:0] m_pal [1<<CW];
  logic m_s1b, m_s1h;
  logic [CW-1:0] m_s1i;
  logic [RW-1:0] m_rgb;
  logic m_val;
  logic [NS-1:0] m_acc, m_col;

  sprite_compositor #(.NSPR(NS), .CIDXW(CW), .COLRW(RW), .BG_COLOR(BG)) dut (
    .clk(clk), .rst(rst), .frame(frame), .bright(bright),
    .spr_drawing(spr_drawing), .spr_pix(spr_pix),
    .pal_we(pal_we), .pal_addr(pal_addr), .pal_data(pal_data),
    .rgb(rgb), .rgb_valid(rgb_valid), .collision(collision), .collision_any(collision_any)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference: a pixel entering at edge t appears at edge t+1 coloured by the palette as it stood before t+1's write.
  task automatic model_edge();
    int first, n;
    logic [NS-1:0] op;
    if (!rst) begin
      for (int i = 0; i < (1<<CW); i++) m_pal[i] = '0;
      m_s1b = 0; m_s1h = 0; m_s1i = '0; m_rgb = '0; m_val = 0; m_acc = '0; m_col = '0;
      return;
    end
    first = -1; n = 0; op = '0;
    for (int i = 0; i < NS; i++)
      if (spr_drawing[i] && spr_pix[i*CW +: CW] != 0) begin
        op[i] = 1'b1;
        n++;
        if (first < 0) first = i;
      end
    m_rgb = !m_s1b ? '0 : (m_s1h ? m_pal[m_s1i] : BG);
    m_val = m_s1b;
    m_s1b = bright;
    m_s1h = (first >= 0);
    m_s1i = (first >= 0) ? spr_pix[first*CW +: CW] : '0;
    if (bright && n >= 2) m_acc = m_acc | op;
    if (frame) begin
      m_col = m_acc;
      m_acc = '0;
    end
    if (pal_we) m_pal[pal_addr] = pal_data;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("rgb", rgb, m_rgb);
    chk("rgb_valid", rgb_valid, m_val);
    chk("collision", collision, m_col);
    chk("collision_any", collision_any, |m_col);
  endtask

  task automatic idle();
    frame = 0; bright = 0; pal_we = 0; spr_drawing = '0; spr_pix = '0; pal_addr = '0; pal_data = '0;
  endtask

  task automatic spr(input int i, input logic [CW-1:0] p);
    spr_drawing[i] = 1'b1;
    spr_pix[i*CW +: CW] = p;
  endtask

  task automatic wr(input logic [CW-1:0] a, input logic [RW-1:0] d);
    pal_we = 1; pal_addr = a; pal_data = d;
  endtask

  initial begin
    idle();
    rst = 0;
    cyc(); cyc();
    chk("reset_rgb", rgb, 0);
    chk("reset_valid", rgb_valid, 0);
    chk("reset_col", collision, 0);
    rst = 1;
    wr(1, 12'hF00); cyc();
    wr(2, 12'h0F0); cyc();
    idle();
    bright = 1; spr(0, 1); spr(1, 2); cyc();
    idle(); cyc();
    chk("priority", rgb, 12'hF00);
    frame = 1; cyc();
    idle();
    bright = 1; spr(1, 2); spr_drawing[0] = 1'b1; cyc();
    idle(); cyc();
    chk("transparent", rgb, 12'h0F0);
    frame = 1; cyc();
    chk("transp_nocol", collision, 0);
    idle();
    spr(0, 1); spr(1, 2); cyc();
    idle(); cyc();
    chk("blank_rgb", rgb, 0);
    chk("blank_valid", rgb_valid, 0);
    bright = 1; cyc();
    idle(); cyc();
    chk("bg_rgb", rgb, BG);
    chk("bg_valid", rgb_valid, 1);
    frame = 1; cyc();
    idle();
    bright = 1; spr(0, 1); spr(2, 3); cyc();
    idle(); cyc();
    frame = 1; cyc();
    chk("col_0101", collision, 4'b0101);
    chk("col_any", collision_any, 1);
    cyc();
    chk("col_clear", collision, 0);
    idle();
    bright = 1; spr(0, 1); cyc();
    wr(1, 12'h00F); cyc();
    chk("rbw_old", rgb, 12'hF00);
    idle(); bright = 1; spr(0, 1); cyc();
    chk("rbw_new", rgb, 12'h00F);
    idle();
    bright = 1; spr(1, 1); spr(3, 2); frame = 1; cyc();
    chk("col_coincident", collision, 4'b1010);
    idle(); frame = 1; cyc();
    chk("col_coinc_once", collision, 0);
    idle();
    bright = 1; spr(0, 1); spr(2, 3); frame = 1; cyc();
    frame = 0; cyc();
    chk("pre_rst_col", collision, 4'b0101);
    rst = 0; wr(1, 12'hFFF); frame = 1; cyc();
    chk("midrst_rgb", rgb, 0);
    chk("midrst_valid", rgb_valid, 0);
    chk("midrst_col", collision, 0);
    rst = 1; idle(); bright = 1; spr(0, 1); cyc();
    chk("post_rst_valid1", rgb_valid, 0);
    cyc();
    chk("post_rst_valid2", rgb_valid, 1);
    chk("pal_cleared", rgb, 0);
    for (int k = 0; k < 800; k++) begin
      rst = ($urandom % 80) != 0;
      frame = ($urandom % 25) == 0;
      bright = ($urandom % 4) != 0;
      spr_drawing = NS'($urandom);
      spr_pix = (NS*CW)'($urandom);
      pal_we = ($urandom % 3) == 0;
      pal_addr = CW'($urandom);
      pal_data = RW'($urandom);
      cyc();
    end
    idle(); cyc(); cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
